pll_lock_seq: RTL and testbench
===============================

Name: pll_lock_seq

Overview:
- Reset/lock sequencer for the 200 MHz fabric PLL. Runs on the free-running 50 MHz board clock that also feeds the PLL input.
- Holds the PLL in reset after power-up, waits for a filtered stable lock, then releases `sys_ready` to the downstream reset tree.
- Re-sequences the PLL on lock loss or on a software request. Declares a fault after repeated lock timeouts.

Parameters:
- RST_HOLD_CYC, 1000: sys_clk cycles pll_rst is held high per attempt (≥1).
- LOCK_STABLE_CYC, 4096: consecutive synced-lock-high cycles required before ready (≥1).
- LOCK_TIMEOUT_CYC, 500000: max cycles in WAIT_LOCK before an attempt fails (≥1).
- MAX_RETRY, 3: failed attempts tolerated; attempt MAX_RETRY+1 failing → FAULT.
- LOSS_FILTER, 4: consecutive synced-lock-low cycles in RUN treated as lock loss (≥1).
- CNT_W, 20: width of the shared cycle counter; must hold max(RST_HOLD_CYC, LOCK_STABLE_CYC, LOCK_TIMEOUT_CYC).

Ports:
- sys_clk, in, 1: 50 MHz free-running clock.
- rst_n, in, 1: asynchronous active-low reset.
- pll_lock, in, 1: raw PLL lock, asynchronous to sys_clk.
- relock_req, in, 1: single-cycle pulse, synchronous; forces a new sequence.
- pll_rst, out, 1: PLL reset, active high.
- sys_ready, out, 1: PLL output valid; drives downstream reset release.
- fault, out, 1: retries exhausted.
- seq_state, out, 3: current state encoding, for debug/status.
- retry_cnt, out, 2: failed attempts in the current sequence.
- loss_cnt, out, 8: lock-loss events since rst_n; saturates at 255.

Behaviour:
- Reset (rst_n=0, async):
  - State RESET, counter 0.
  - pll_rst=1, sys_ready=0, fault=0, retry_cnt=0, loss_cnt=0.
  - Synchroniser flops cleared to 0.
- Lock input: pll_lock passes through a 2-flop synchroniser to give lock_s. All decisions use lock_s, so there are 2 cycles of input latency.
- All outputs are registered. pll_rst, sys_ready and fault are decoded from the registered state.
- States and transitions:
  - RESET (0):
    - pll_rst=1; counter increments.
    - At counter==RST_HOLD_CYC-1: counter←0, go to WAIT_LOCK.
  - WAIT_LOCK (1):
    - pll_rst=0; counter increments.
    - If lock_s=1: counter←0, go to STABLE.
    - Else if counter==LOCK_TIMEOUT_CYC-1:
      - if retry_cnt==MAX_RETRY, go to FAULT;
      - otherwise retry_cnt+1, counter←0, go to RESET.
  - STABLE (2):
    - If lock_s=0: counter←0, return to WAIT_LOCK. The timeout restarts; this is not a retry.
    - Else counter increments; at LOCK_STABLE_CYC-1 go to RUN and clear retry_cnt.
  - RUN (3):
    - sys_ready=1; a loss counter tracks consecutive lock_s=0.
    - Any lock_s=1 clears the loss counter.
    - When it reaches LOSS_FILTER: loss_cnt+1 (saturating), counter←0, go to RESET.
    - sys_ready drops on the cycle after the decision.
  - FAULT (4):
    - pll_rst=1, fault=1, sys_ready=0.
    - Stays here until relock_req or rst_n.
- relock_req:
  - In any state, go to RESET with counter←0 and retry_cnt←0.
  - fault clears on the next cycle.
  - loss_cnt is not incremented.
  - relock_req has priority over every other transition in the same cycle.
- Simultaneous events:
  - Timeout and lock_s rising in the same cycle: lock wins, go to STABLE.
  - Loss-filter expiry and relock_req in the same cycle: relock wins, loss_cnt is unchanged.
- Glitch rule: a 1-cycle lock_s drop in RUN with LOSS_FILTER>1 has no effect on sys_ready.
- Counter compares use the full counter width; it never wraps inside a state.

Decomposition:
- Shared package `pll_seq_pkg`:
  - State localparams ST_RESET=0, ST_WAIT=1, ST_STABLE=2, ST_RUN=3, ST_FAULT=4.
  - SEQ_STATE_W=3.
- Sub-module `sync_2ff`:
  - Parameterised width.
  - Async active-low clear, same clock and reset port names.
  - Reused for other async status inputs.

Test Plan (RST_HOLD_CYC=8, LOCK_STABLE_CYC=16, LOCK_TIMEOUT_CYC=64, MAX_RETRY=3, LOSS_FILTER=4):
- Nominal bring-up:
  - Release rst_n; raise pll_lock 5 cycles after pll_rst falls.
  - pll_rst high exactly 8 cycles.
  - sys_ready rises 2+16+1 cycles after pll_lock rises (±1 for sync alignment).
  - retry_cnt=0.
- Timeout/fault:
  - Hold pll_lock=0.
  - Expect 4 RESET pulses of 8 cycles separated by 64-cycle waits, then fault=1 and pll_rst=1.
  - retry_cnt=3.
  - Pulse relock_req → fault=0 next cycle, new RESET pulse.
- Lock chatter in STABLE:
  - Drop pll_lock for 1 cycle 10 cycles into STABLE.
  - Return to WAIT_LOCK with retry_cnt unchanged; sys_ready only after a full 16-cycle clean window.
- RUN glitch vs loss:
  - 3-cycle low pulse → sys_ready stays 1, loss_cnt=0.
  - 4-cycle low pulse → sys_ready falls, loss_cnt=1, pll_rst re-asserts for 8 cycles, then relock completes.
- Reset mid-operation:
  - Assert rst_n=0 asynchronously in STABLE and in RUN.
  - All outputs reach reset values without a clock edge; loss_cnt=0.
- Priority:
  - relock_req in the same cycle as loss-filter expiry → RESET, loss_cnt unchanged.
  - relock_req in the same cycle as WAIT_LOCK timeout → retry_cnt=0.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset/lock sequencer.
// Contents:
//   SEQ_STATE_W       - width of the exported state encoding
//   ST_*              - numeric state encodings seen on seq_state
//   seq_state_e       - FSM state type built on those encodings
//   sat_inc8()        - saturating 8-bit increment for event counters
package pll_seq_pkg;

    localparam int SEQ_STATE_W = 3;

    localparam logic [SEQ_STATE_W-1:0] ST_RESET  = 3'd0;
    localparam logic [SEQ_STATE_W-1:0] ST_WAIT   = 3'd1;
    localparam logic [SEQ_STATE_W-1:0] ST_STABLE = 3'd2;
    localparam logic [SEQ_STATE_W-1:0] ST_RUN    = 3'd3;
    localparam logic [SEQ_STATE_W-1:0] ST_FAULT  = 3'd4;

    typedef enum logic [SEQ_STATE_W-1:0] {
        StReset  = ST_RESET,
        StWait   = ST_WAIT,
        StStable = ST_STABLE,
        StRun    = ST_RUN,
        StFault  = ST_FAULT
    } seq_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pll_lock_seq_if.sv
// Status/control bundle between the PLL lock sequencer and its surroundings.
// Signals:
//   pll_lock   - raw PLL lock (asynchronous to sys_clk)
//   relock_req - single-cycle request to restart the sequence
//   pll_rst    - PLL reset, active high
//   sys_ready  - PLL output valid, releases the downstream reset tree
//   fault      - lock attempts exhausted
//   seq_state  - current sequencer state encoding
//   retry_cnt  - failed attempts in the current sequence
//   loss_cnt   - lock-loss events since reset, saturating
// Modports: master = sequencer side, slave = PLL/system side.
interface pll_lock_seq_if;
    import pll_seq_pkg::*;

    logic                   pll_lock;
    logic                   relock_req;
    logic                   pll_rst;
    logic                   sys_ready;
    logic                   fault;
    logic [SEQ_STATE_W-1:0] seq_state;
    logic [1:0]             retry_cnt;
    logic [7:0]             loss_cnt;

    modport master (
        input  pll_lock,
        input  relock_req,
        output pll_rst,
        output sys_ready,
        output fault,
        output seq_state,
        output retry_cnt,
        output loss_cnt
    );

    modport slave (
        output pll_lock,
        output relock_req,
        input  pll_rst,
        input  sys_ready,
        input  fault,
        input  seq_state,
        input  retry_cnt,
        input  loss_cnt
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
// Ports:
//   sys_clk - destination clock
//   rst_n   - asynchronous active-low clear
//   d       - asynchronous input bus (bits synchronised independently)
//   q       - synchronised output, two cycles of latency
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_lock_seq.sv
// Reset/lock sequencer for the fabric PLL, clocked by the free-running board clock.
// Holds the PLL in reset, waits for a filtered stable lock, then raises sys_ready.
// Re-sequences on lock loss or relock_req; declares fault after repeated timeouts.
// Ports:
//   sys_clk - free-running board clock
//   rst_n   - asynchronous active-low reset
//   bus     - pll_lock_seq_if.master: lock input, relock request, status outputs
module pll_lock_seq
    import pll_seq_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYC     = 1000,
    parameter int unsigned LOCK_STABLE_CYC  = 4096,
    parameter int unsigned LOCK_TIMEOUT_CYC = 500000,
    parameter int unsigned MAX_RETRY        = 3,
    parameter int unsigned LOSS_FILTER      = 4,
    parameter int unsigned CNT_W            = 20
) (
    input logic            sys_clk,
    input logic            rst_n,
    pll_lock_seq_if.master bus
);

    localparam int unsigned LF_W = $clog2(LOSS_FILTER + 1);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRY);
    localparam logic [LF_W-1:0]  LF_LIMIT     = LF_W'(LOSS_FILTER);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       retry_q, retry_d;
    logic [7:0]       loss_q, loss_d;
    logic [LF_W-1:0]  lossf_q, lossf_d, lossf_inc;
    logic             lock_s;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .d       (bus.pll_lock),
        .q       (lock_s)
    );

    assign lossf_inc = lossf_q + LF_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        // Consecutive-low filter only counts while in RUN.
        lossf_d = '0;

        if (bus.relock_req) begin
            // Overrides every other transition, including a loss-filter expiry.
            state_d = StReset;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                StReset: begin
                    if (cnt_q == RST_LAST) begin
                        cnt_d   = '0;
                        state_d = StWait;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StWait: begin
                    // Lock beats a coincident timeout.
                    if (lock_s) begin
                        cnt_d   = '0;
                        state_d = StStable;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        cnt_d = '0;
                        if (retry_q == RETRY_MAX) begin
                            state_d = StFault;
                        end else begin
                            retry_d = retry_q + 2'd1;
                            state_d = StReset;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StStable: begin
                    // A drop restarts the lock wait without costing a retry.
                    if (!lock_s) begin
                        cnt_d   = '0;
                        state_d = StWait;
                    end else if (cnt_q == STABLE_LAST) begin
                        cnt_d   = '0;
                        retry_d = '0;
                        state_d = StRun;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StRun: begin
                    if (lock_s) begin
                        lossf_d = '0;
                    end else if (lossf_inc == LF_LIMIT) begin
                        loss_d  = sat_inc8(loss_q);
                        cnt_d   = '0;
                        state_d = StReset;
                    end else begin
                        lossf_d = lossf_inc;
                    end
                end
                StFault: begin
                    state_d = StFault;
                end
                default: begin
                    cnt_d   = '0;
                    state_d = StReset;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StReset;
            cnt_q   <= '0;
            retry_q <= '0;
            loss_q  <= '0;
            lossf_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            loss_q  <= loss_d;
            lossf_q <= lossf_d;
        end
    end

    assign bus.pll_rst   = (state_q == StReset) || (state_q == StFault);
    assign bus.sys_ready = (state_q == StRun);
    assign bus.fault     = (state_q == StFault);
    assign bus.seq_state = state_q;
    assign bus.retry_cnt = retry_q;
    assign bus.loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_lock_seq.sv
// Testbench for pll_lock_seq. Each segment builds a lock/relock waveform, derives the
// expected state-change events from the sequencing rules, queues them, then drives the
// waveform; a monitor pops and compares whenever the DUT outputs change.
module tb_pll_lock_seq;
    import pll_seq_pkg::*;

    localparam int RST_HOLD = 8;
    localparam int STABLE   = 16;
    localparam int TIMEOUT  = 64;
    localparam int MAXR     = 3;
    localparam int LF       = 4;
    localparam int MAXN     = 1023;

    typedef struct {
        int cyc;
        int st;
        int rt;
        int ls;
    } ev_t;

    logic sys_clk;
    logic rst_n;
    pll_lock_seq_if bus ();

    pll_lock_seq #(
        .RST_HOLD_CYC     (RST_HOLD),
        .LOCK_STABLE_CYC  (STABLE),
        .LOCK_TIMEOUT_CYC (TIMEOUT),
        .MAX_RETRY        (MAXR),
        .LOSS_FILTER      (LF),
        .CNT_W            (20)
    ) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    int  tests = 0;
    int  fails = 0;
    int  cyc   = 0;
    bit  lk [0:MAXN];
    bit  rl [0:MAXN];
    ev_t mev[$];
    ev_t expq[$];
    logic [15:0] prev_t;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] out_tuple();
        return {bus.seq_state, bus.retry_cnt, bus.loss_cnt,
                bus.pll_rst, bus.sys_ready, bus.fault};
    endfunction

    // Monitor: any change in the visible outputs must match the next queued event.
    always @(negedge sys_clk) begin
        if (!rst_n) begin
            prev_t <= {3'd0, 2'd0, 8'd0, 1'b1, 1'b0, 1'b0};
        end else if (out_tuple() != prev_t) begin
            prev_t <= out_tuple();
            check("event_pending", int'(expq.size() > 0), 1);
            if (expq.size() > 0) begin
                ev_t e;
                e = expq.pop_front();
                check("event_cycle", cyc, e.cyc);
                check("seq_state", int'(bus.seq_state), e.st);
                check("retry_cnt", int'(bus.retry_cnt), e.rt);
                check("loss_cnt", int'(bus.loss_cnt), e.ls);
                check("pll_rst", int'(bus.pll_rst),
                      int'(e.st == int'(ST_RESET) || e.st == int'(ST_FAULT)));
                check("sys_ready", int'(bus.sys_ready), int'(e.st == int'(ST_RUN)));
                check("fault", int'(bus.fault), int'(e.st == int'(ST_FAULT)));
            end
        end
    end

    // Synchronised lock seen by the sequencer at edge k after reset release.
    function automatic bit lock_s_at(input int k);
        if (k >= 3 && k - 2 <= MAXN) return lk[k-2];
        return 1'b0;
    endfunction

    // Reference: walk phase by phase, finding each phase's end by searching the waveform.
    task automatic run_model(input int n);
        int st, start, rt, ls, t, nst, nrt, nls, r;
        bit all_low;
        mev.delete();
        st = int'(ST_RESET); start = 0; rt = 0; ls = 0;
        while (1) begin
            t = n + 1; nst = st; nrt = rt; nls = ls;
            if (st == int'(ST_RESET)) begin
                t = start + RST_HOLD; nst = int'(ST_WAIT);
            end else if (st == int'(ST_WAIT)) begin
                t = start + TIMEOUT;
                if (rt == MAXR) nst = int'(ST_FAULT);
                else begin nst = int'(ST_RESET); nrt = rt + 1; end
                for (int e = start + 1; e <= start + TIMEOUT; e++) begin
                    if (lock_s_at(e)) begin t = e; nst = int'(ST_STABLE); nrt = rt; break; end
                end
            end else if (st == int'(ST_STABLE)) begin
                t = start + STABLE; nst = int'(ST_RUN); nrt = 0;
                for (int e = start + 1; e <= start + STABLE; e++) begin
                    if (!lock_s_at(e)) begin t = e; nst = int'(ST_WAIT); nrt = rt; break; end
                end
            end else if (st == int'(ST_RUN)) begin
                for (int e = start + LF; e <= n; e++) begin
                    all_low = 1'b1;
                    for (int j = 0; j < LF; j++) if (lock_s_at(e - j)) all_low = 1'b0;
                    if (all_low) begin
                        t = e; nst = int'(ST_RESET); nls = (ls >= 255) ? 255 : ls + 1;
                        break;
                    end
                end
            end
            r = 0;
            for (int e = start + 1; e <= t && e <= n; e++) begin
                if (rl[e]) begin r = e; break; end
            end
            if (r != 0) begin t = r; nst = int'(ST_RESET); nrt = 0; nls = ls; end
            if (t > n) break;
            if (nst != st || nrt != rt || nls != ls) mev.push_back('{t, nst, nrt, nls});
            st = nst; rt = nrt; ls = nls; start = t;
        end
    endtask

    task automatic clear_wave();
        for (int i = 0; i <= MAXN; i++) begin lk[i] = 1'b0; rl[i] = 1'b0; end
    endtask

    task automatic set_lock(input int from, input int to, input bit v);
        for (int i = from; i <= to; i++) lk[i] = v;
    endtask

    task automatic reset_checks(input string tag);
        check({"rst_pll_rst_", tag}, int'(bus.pll_rst), 1);
        check({"rst_sys_ready_", tag}, int'(bus.sys_ready), 0);
        check({"rst_fault_", tag}, int'(bus.fault), 0);
        check({"rst_state_", tag}, int'(bus.seq_state), int'(ST_RESET));
        check({"rst_retry_", tag}, int'(bus.retry_cnt), 0);
        check({"rst_loss_", tag}, int'(bus.loss_cnt), 0);
    endtask

    // Enters with rst_n low; releases, drives n edges, then asserts reset mid-cycle.
    task automatic run_segment(input int n, input string tag);
        int base;
        run_model(n);
        @(posedge sys_clk); #1;
        rst_n = 1'b1;
        base  = cyc;
        foreach (mev[i]) expq.push_back('{base + mev[i].cyc, mev[i].st, mev[i].rt, mev[i].ls});
        for (int k = 1; k <= n; k++) begin
            bus.pll_lock   = lk[k];
            bus.relock_req = rl[k];
            @(posedge sys_clk); #1;
        end
        bus.relock_req = 1'b0;
        @(negedge sys_clk); #2;
        check({"events_drained_", tag}, expq.size(), 0);
        expq.delete();
        rst_n        = 1'b0;
        bus.pll_lock = 1'b0;
        #1;
        reset_checks(tag);
        repeat (2) @(posedge sys_clk);
    endtask

    initial begin
        int k, len, kl;
        bit lv;
        rst_n          = 1'b0;
        bus.pll_lock   = 1'b0;
        bus.relock_req = 1'b0;
        #1;
        reset_checks("power_up");
        repeat (3) @(posedge sys_clk);

        // Nominal bring-up: lock 5 cycles after pll_rst falls; reset lands in RUN.
        clear_wave(); set_lock(13, 60, 1'b1);
        run_segment(60, "nominal");

        // Lock never arrives: retries, fault, then relock_req.
        clear_wave(); rl[300] = 1'b1;
        run_segment(320, "timeout_fault");

        // One-cycle drop 10 cycles into STABLE; reset lands in STABLE.
        clear_wave(); set_lock(13, 40, 1'b1); lk[25] = 1'b0;
        run_segment(40, "chatter");

        // RUN: 3-cycle glitch is filtered, 4-cycle drop is a loss and re-sequences.
        clear_wave(); set_lock(13, 110, 1'b1); set_lock(40, 42, 1'b0); set_lock(60, 63, 1'b0);
        run_segment(110, "glitch_loss");

        // relock_req coincident with loss-filter expiry.
        clear_wave(); set_lock(13, 100, 1'b1); set_lock(60, 63, 1'b0);
        run_model(100);
        kl = -1;
        foreach (mev[i]) if (kl < 0 && mev[i].ls == 1) kl = mev[i].cyc;
        if (kl > 0) rl[kl] = 1'b1;
        run_segment(100, "prio_loss");

        // relock_req coincident with a WAIT_LOCK timeout.
        clear_wave();
        run_model(150);
        kl = -1;
        foreach (mev[i]) if (kl < 0 && mev[i].rt == 1) kl = mev[i].cyc;
        if (kl > 0) rl[kl] = 1'b1;
        run_segment(150, "prio_timeout");

        // Randomised lock waveforms with occasional relock requests.
        for (int s = 0; s < 10; s++) begin
            int n;
            n = $urandom_range(200, 700);
            clear_wave();
            k  = 1;
            lv = 1'(($urandom_range(0, 1)));
            while (k <= n) begin
                if (lv) len = $urandom_range(1, 150);
                else if ($urandom_range(0, 1) == 1) len = $urandom_range(1, 6);
                else len = $urandom_range(7, 120);
                for (int j = 0; j < len && k <= n; j++) begin lk[k] = lv; k++; end
                lv = !lv;
            end
            for (int i = 1; i <= n; i++) rl[i] = ($urandom_range(0, 199) == 0);
            run_segment(n, $sformatf("rand%0d", s));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
